rx_control_unit: RTL and testbench

Receive-path sequencer for the APB UART receiver. Validates a detected start bit at mid-bit, then enables the bit timer, hands the stop bit to the stop-bit checker, and either loads the received byte into the RX buffer or discards the frame on a framing error. Sits between the start-bit edge detector, the `timer` (`enable_timer`/`packet_done`), the stop-bit checker and the RX data buffer.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/start_bit_counter.sv | 24 ++
 rtl/rx_control_unit.sv | 95 +++++++++
 tb/tb_rx_control_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: controller states and the
// half-bit timing constant that the bit timer also derives its period from.
package uart_rx_pkg;

    // Cycles from start-edge detection to the start-bit mid-point sample.
    localparam int HALF_BIT_DEFAULT = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        GLITCH    = 3'd2,
        RECEIVE   = 3'd3,
        STOP_CHK  = 3'd4,
        STOP_EVAL = 3'd5,
        LOAD      = 3'd6
    } rx_ctrl_state_t;

    // Width of a counter that must reach half_bit without wrapping.
    function automatic int start_cnt_w(input int half_bit);
        return $clog2(half_bit + 1);
    endfunction

endpackage

// File: rtl/start_bit_counter.sv
// Clear/enable up-counter with a terminal-count flag. Saturates at TERM so it
// never wraps even if the enable is left high.
module start_bit_counter #(
    parameter int WIDTH = 3,
    parameter int TERM  = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == WIDTH'(TERM));

    // Clear has priority; increment only while enabled and below terminal.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)          count <= '0;
        else if (clr)        count <= '0;
        else if (en && !tc)  count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/rx_control_unit.sv
// Receive-path sequencer: validates the start bit at mid-bit, runs the bit
// timer over data + stop, strobes the stop-bit checker, then either loads the
// byte into the RX buffer or drops the frame on a framing error.
module rx_control_unit
    import uart_rx_pkg::*;
#(
    parameter int HALF_BIT = HALF_BIT_DEFAULT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic new_packet_detected,
    input  logic serial_in_sync,
    input  logic packet_done,
    input  logic framing_error,
    output logic sbc_clear,
    output logic sbc_enable,
    output logic enable_timer,
    output logic load_buffer,
    output logic start_glitch,
    output logic busy
);

    localparam int CNT_W = start_cnt_w(HALF_BIT);

    rx_ctrl_state_t   state, state_d;
    logic [CNT_W-1:0] start_cnt;
    logic             start_tc;
    logic             cnt_clr;
    logic             cnt_en;

    // Counter only runs in START_CHK; it is zeroed on the terminal cycle so
    // it already reads 0 the moment the FSM leaves START_CHK.
    assign cnt_en  = (state == START_CHK);
    assign cnt_clr = !cnt_en || start_tc;

    start_bit_counter #(
        .WIDTH (CNT_W),
        .TERM  (HALF_BIT - 1)
    ) u_start_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (start_cnt),
        .tc    (start_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d      = state;
        sbc_clear    = 1'b0;
        sbc_enable   = 1'b0;
        enable_timer = 1'b0;
        load_buffer  = 1'b0;
        start_glitch = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (new_packet_detected) state_d = START_CHK;
            end
            START_CHK: begin
                sbc_clear = 1'b1;
                // Line still low at mid-bit means a real start bit.
                if (start_tc) state_d = serial_in_sync ? GLITCH : RECEIVE;
            end
            GLITCH: begin
                start_glitch = 1'b1;
                state_d      = IDLE;
            end
            RECEIVE: begin
                enable_timer = 1'b1;
                if (packet_done) state_d = STOP_CHK;
            end
            STOP_CHK: begin
                sbc_enable = 1'b1;
                state_d    = STOP_EVAL;
            end
            STOP_EVAL: begin
                state_d = framing_error ? IDLE : LOAD;
            end
            LOAD: begin
                load_buffer = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_control_unit.sv
// Bench for rx_control_unit: vector table on a HALF_BIT=5 instance through a
// scoreboard queue, plus hand sequences for async reset and HALF_BIT=1.
module tb_rx_control_unit;

    logic clk = 1'b0;
    logic n_rst;
    logic npd, sin, pd, fe;
    logic sc, se, et, lb, sg, bz;
    logic npd1, sin1, pd1, fe1;
    logic sc1, se1, et1, lb1, sg1, bz1;
    logic [5:0] o, o1;

    always #5 clk = ~clk;

    assign o  = {sc,  se,  et,  lb,  sg,  bz};
    assign o1 = {sc1, se1, et1, lb1, sg1, bz1};

    rx_control_unit #(.HALF_BIT(5)) dut (
        .clk(clk), .n_rst(n_rst),
        .new_packet_detected(npd), .serial_in_sync(sin),
        .packet_done(pd), .framing_error(fe),
        .sbc_clear(sc), .sbc_enable(se), .enable_timer(et),
        .load_buffer(lb), .start_glitch(sg), .busy(bz)
    );

    rx_control_unit #(.HALF_BIT(1)) dut1 (
        .clk(clk), .n_rst(n_rst),
        .new_packet_detected(npd1), .serial_in_sync(sin1),
        .packet_done(pd1), .framing_error(fe1),
        .sbc_clear(sc1), .sbc_enable(se1), .enable_timer(et1),
        .load_buffer(lb1), .start_glitch(sg1), .busy(bz1)
    );

    // Output patterns {sbc_clear, sbc_enable, enable_timer, load_buffer, start_glitch, busy}
    localparam logic [5:0] O_ID = 6'b000000;
    localparam logic [5:0] O_SC = 6'b100001;
    localparam logic [5:0] O_GL = 6'b000011;
    localparam logic [5:0] O_RX = 6'b001001;
    localparam logic [5:0] O_SE = 6'b010001;
    localparam logic [5:0] O_EV = 6'b000001;
    localparam logic [5:0] O_LD = 6'b000101;

    // Inputs {new_packet_detected, serial_in_sync, packet_done, framing_error}
    localparam logic [3:0] I_ID  = 4'b0100;  // idle line
    localparam logic [3:0] I_NP  = 4'b1100;  // start edge pulse
    localparam logic [3:0] I_LO  = 4'b0000;  // line low
    localparam logic [3:0] I_HI  = 4'b0100;  // line high
    localparam logic [3:0] I_PD  = 4'b0010;  // packet_done
    localparam logic [3:0] I_FE  = 4'b0001;  // framing_error
    localparam logic [3:0] I_NPL = 4'b1000;  // npd with line low
    localparam logic [3:0] I_FEL = 4'b0001;  // framing_error, line low

    typedef struct {
        logic [3:0] in;
        logic [5:0] exp;   // outputs expected in the following cycle
        string      nm;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sb[$];
    string      sbn[$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] i, input logic [5:0] e, input string nm);
        vec_t v;
        v.in = i; v.exp = e; v.nm = nm;
        vecs.push_back(v);
    endtask

    // One cycle: retire the pending expectation, drive new inputs, queue result.
    task automatic cyc(input logic [3:0] i, input logic [5:0] e, input string nm);
        @(negedge clk);
        if (sb.size() > 0) chk(sbn.pop_front(), o, sb.pop_front());
        {npd, sin, pd, fe} = i;
        sb.push_back(e);
        sbn.push_back(nm);
    endtask

    task automatic flush();
        while (sb.size() > 0) begin
            @(negedge clk);
            chk(sbn.pop_front(), o, sb.pop_front());
            {npd, sin, pd, fe} = I_ID;
        end
    endtask

    initial begin
        n_rst = 1'b0;
        {npd, sin, pd, fe}     = I_ID;
        {npd1, sin1, pd1, fe1} = I_ID;

        // ---- vector table ----
        // good frame, with ignored npd in RECEIVE and npd in LOAD
        add(I_NP, O_SC, "good_n1");
        for (int k = 0; k < 4; k++) add(I_LO, O_SC, "good_sc");
        add(I_LO,  O_RX, "good_sample");
        add(I_FEL, O_RX, "rx_fe_ign");
        add(I_NPL, O_RX, "rx_npd_ign");
        add(I_LO,  O_RX, "rx_hold");
        add(I_PD,  O_SE, "good_p1");
        add(I_FE,  O_EV, "good_p2_fe_ign");
        add(I_ID,  O_LD, "good_p3_load");
        add(I_NP,  O_ID, "load_npd_ign");
        add(I_ID,  O_ID, "idle");
        add(I_PD,  O_ID, "idle_pd_ign");
        // start glitch, npd in GLITCH ignored, restart after one idle cycle
        add(I_NP, O_SC, "gl_n1");
        for (int k = 0; k < 4; k++) add(I_HI, O_SC, "gl_sc");
        add(I_HI, O_GL, "gl_pulse");
        add(I_NP, O_ID, "gl_npd_ign");
        add(I_NP, O_SC, "restart");
        // framing error frame
        for (int k = 0; k < 4; k++) add(I_LO, O_SC, "fe_sc");
        add(I_LO,  O_RX, "fe_sample");
        add(I_LO,  O_RX, "fe_rx");
        add(I_PD,  O_SE, "fe_p1");
        add(I_LO,  O_EV, "fe_p2");
        add(I_FEL, O_ID, "fe_p3_drop");
        add(I_NP,  O_SC, "fe_next_accept");
        for (int k = 0; k < 4; k++) add(I_HI, O_SC, "tail_sc");
        add(I_HI, O_GL, "tail_gl");
        add(I_ID, O_ID, "tail_idle");

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("reset_out", o, O_ID);
        chk("reset_out_hb1", o1, O_ID);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", o, O_ID);

        for (int k = 0; k < vecs.size(); k++) cyc(vecs[k].in, vecs[k].exp, vecs[k].nm);
        flush();

        // ---- asynchronous reset in RECEIVE ----
        cyc(I_NP, O_SC, "r_n1");
        for (int k = 0; k < 4; k++) cyc(I_LO, O_SC, "r_sc");
        cyc(I_LO, O_RX, "r_sample");
        flush();
        chk1("r_in_receive", et, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk1("rst_async_timer", et, 1'b0);
        chk1("rst_async_busy", bz, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(I_NP, O_SC, "r_accept");
        for (int k = 0; k < 4; k++) cyc(I_HI, O_SC, "r_sc2");
        cyc(I_HI, O_GL, "r_gl");
        cyc(I_ID, O_ID, "r_idle");
        flush();

        // ---- HALF_BIT = 1 boundary ----
        @(negedge clk);
        npd1 = 1'b1; sin1 = 1'b1;
        @(negedge clk);                        // N+1
        npd1 = 1'b0; sin1 = 1'b0;
        chk1("hb1_clear_n1", sc1, 1'b1);
        chk1("hb1_timer_n1", et1, 1'b0);
        @(negedge clk);                        // N+2
        chk1("hb1_clear_n2", sc1, 1'b0);
        chk1("hb1_timer_n2", et1, 1'b1);
        pd1 = 1'b1;
        @(negedge clk);
        pd1 = 1'b0;
        chk1("hb1_sbc_en", se1, 1'b1);
        @(negedge clk);
        chk1("hb1_eval_busy", bz1, 1'b1);
        @(negedge clk);
        chk1("hb1_load", lb1, 1'b1);
        @(negedge clk);
        chk1("hb1_idle", bz1, 1'b0);
        npd1 = 1'b1; sin1 = 1'b1;              // glitch start
        @(negedge clk);
        npd1 = 1'b0;
        chk1("hb1_gl_clear", sc1, 1'b1);
        @(negedge clk);
        chk1("hb1_glitch", sg1, 1'b1);
        chk1("hb1_gl_timer", et1, 1'b0);
        @(negedge clk);
        chk1("hb1_gl_idle", bz1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
